// File: rtl/rvx10_pkg.sv
// Shared RVX10 pipeline types: ALU op codes, forwarding selects and the ID/EX, EX/MEM payloads.
package rvx10_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned SHW  = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_MIN = 4'b0111,
        ALU_MAX = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [3:0]      alucontrol;
        logic            alusrc;
        logic            regwrite;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic [1:0]      resultsrc;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic [1:0]      resultsrc;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] aluresult;
        logic [XLEN-1:0] writedata;
    } exmem_t;

endpackage

// File: rtl/alu.sv
// RVX10 ALU: base integer ops plus signed MIN/MAX; unassigned codes yield zero.
module alu
    import rvx10_pkg::*;
(
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic [3:0]      alucontrol,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [SHW-1:0] shamt;
    logic           a_lt_b;

    assign shamt  = srcb[SHW-1:0];
    assign a_lt_b = $signed(srca) < $signed(srcb);

    always_comb begin
        result = '0;
        case (alucontrol)
            4'(ALU_ADD): result = srca + srcb;
            4'(ALU_SUB): result = srca - srcb;
            4'(ALU_AND): result = srca & srcb;
            4'(ALU_OR):  result = srca | srcb;
            4'(ALU_XOR): result = srca ^ srcb;
            4'(ALU_SLL): result = srca << shamt;
            4'(ALU_SRL): result = srca >> shamt;
            4'(ALU_MIN): result = a_lt_b ? srca : srcb;
            4'(ALU_MAX): result = a_lt_b ? srcb : srca;
            default:     result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// RVX10 execute stage: ID/EX register, operand forwarding, ALU, branch resolution, EX/MEM register.
module execute_stage
    import rvx10_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_pcplus4,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [3:0]      id_alucontrol,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic            id_memwrite,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic [1:0]      id_resultsrc,
    input  logic            flush_e,
    input  logic [1:0]      forward_ae,
    input  logic [1:0]      forward_be,
    input  logic [XLEN-1:0] mem_aluresult,
    input  logic [XLEN-1:0] wb_result,
    output logic [REGW-1:0] e_rs1,
    output logic [REGW-1:0] e_rs2,
    output logic [REGW-1:0] e_rd,
    output logic            e_regwrite,
    output logic            e_resultsrc0,
    output logic            pcsrc_e,
    output logic [XLEN-1:0] pctarget_e,
    output logic            m_valid,
    output logic            m_regwrite,
    output logic            m_memwrite,
    output logic [1:0]      m_resultsrc,
    output logic [XLEN-1:0] m_aluresult,
    output logic [XLEN-1:0] m_writedata,
    output logic [XLEN-1:0] m_pcplus4,
    output logic [REGW-1:0] m_rd
);

    idex_t           id_d, e_q;
    exmem_t          m_d, m_q;
    logic [XLEN-1:0] srca, fwdb, srcb, aluresult;
    logic            zero;

    // Flushed or empty slots enter EX as an all-zero bubble.
    always_comb begin
        id_d = '0;
        if (id_valid && !flush_e) begin
            id_d.valid      = 1'b1;
            id_d.pc         = id_pc;
            id_d.pcplus4    = id_pcplus4;
            id_d.rd1        = id_rd1;
            id_d.rd2        = id_rd2;
            id_d.imm        = id_imm;
            id_d.rs1        = id_rs1;
            id_d.rs2        = id_rs2;
            id_d.rd         = id_rd;
            id_d.alucontrol = id_alucontrol;
            id_d.alusrc     = id_alusrc;
            id_d.regwrite   = id_regwrite;
            id_d.memwrite   = id_memwrite;
            id_d.branch     = id_branch;
            id_d.jump       = id_jump;
            id_d.resultsrc  = id_resultsrc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
        end else begin
            e_q <= id_d;
        end
    end

    always_comb begin
        srca = e_q.rd1;
        case (fwd_sel_e'(forward_ae))
            FWD_WB:  srca = wb_result;
            FWD_MEM: srca = mem_aluresult;
            default: srca = e_q.rd1;
        endcase
    end

    always_comb begin
        fwdb = e_q.rd2;
        case (fwd_sel_e'(forward_be))
            FWD_WB:  fwdb = wb_result;
            FWD_MEM: fwdb = mem_aluresult;
            default: fwdb = e_q.rd2;
        endcase
    end

    assign srcb = e_q.alusrc ? e_q.imm : fwdb;

    alu u_alu (
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (e_q.alucontrol),
        .result     (aluresult),
        .zero       (zero)
    );

    assign pcsrc_e    = e_q.valid & ((e_q.branch & zero) | e_q.jump);
    assign pctarget_e = e_q.pc + e_q.imm;

    // Store data is the forwarded rs2 value, independent of the immediate select.
    always_comb begin
        m_d           = '0;
        m_d.valid     = e_q.valid;
        m_d.regwrite  = e_q.valid & e_q.regwrite;
        m_d.memwrite  = e_q.valid & e_q.memwrite;
        m_d.resultsrc = e_q.resultsrc;
        m_d.rd        = e_q.rd;
        m_d.pcplus4   = e_q.pcplus4;
        m_d.aluresult = aluresult;
        m_d.writedata = fwdb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q <= '0;
        end else begin
            m_q <= m_d;
        end
    end

    assign e_rs1        = e_q.rs1;
    assign e_rs2        = e_q.rs2;
    assign e_rd         = e_q.rd;
    assign e_regwrite   = e_q.regwrite;
    assign e_resultsrc0 = e_q.resultsrc[0];

    assign m_valid      = m_q.valid;
    assign m_regwrite   = m_q.regwrite;
    assign m_memwrite   = m_q.memwrite;
    assign m_resultsrc  = m_q.resultsrc;
    assign m_aluresult  = m_q.aluresult;
    assign m_writedata  = m_q.writedata;
    assign m_pcplus4    = m_q.pcplus4;
    assign m_rd         = m_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed instructions push expected EX and MEM responses, a negedge monitor checks them.
module tb_execute_stage;
    import rvx10_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_pcplus4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alucontrol;
    logic        id_alusrc, id_regwrite, id_memwrite, id_branch, id_jump;
    logic [1:0]  id_resultsrc;
    logic        flush_e;
    logic [1:0]  forward_ae, forward_be;
    logic [31:0] mem_aluresult, wb_result;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_regwrite, e_resultsrc0, pcsrc_e;
    logic [31:0] pctarget_e;
    logic        m_valid, m_regwrite, m_memwrite;
    logic [1:0]  m_resultsrc;
    logic [31:0] m_aluresult, m_writedata, m_pcplus4;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_pc(id_pc), .id_pcplus4(id_pcplus4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alucontrol(id_alucontrol),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_jump(id_jump), .id_resultsrc(id_resultsrc),
        .flush_e(flush_e), .forward_ae(forward_ae), .forward_be(forward_be),
        .mem_aluresult(mem_aluresult), .wb_result(wb_result),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_regwrite(e_regwrite), .e_resultsrc0(e_resultsrc0),
        .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memwrite(m_memwrite), .m_resultsrc(m_resultsrc),
        .m_aluresult(m_aluresult), .m_writedata(m_writedata), .m_pcplus4(m_pcplus4), .m_rd(m_rd)
    );

    typedef struct {
        logic        rst, flush, valid;
        logic [31:0] pc, pcplus4, rd1, rd2, imm;
        logic [4:0]  rd;
        logic [3:0]  aluc;
        logic        alusrc, regwrite, memwrite, branch, jump;
        logic [1:0]  resultsrc, fa, fb;
        logic [31:0] memres, wbres;
    } stim_t;

    typedef struct {
        int          due;
        logic        pcsrc;
        logic [31:0] target;
        logic [4:0]  rd;
        logic        regw;
    } exp_e_t;

    typedef struct {
        int          due;
        logic        valid, regw, memw;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] alu, wdata, pcp4;
    } exp_m_t;

    exp_e_t eq[$];
    exp_m_t mq[$];
    int cyc = 0;
    int nchk = 0;
    int nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic stim_t alu_i(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] rd);
        stim_t s;
        s = '{default: '0};
        s.valid    = 1'b1;
        s.aluc     = op;
        s.rd1      = a;
        s.rd2      = b;
        s.rd       = rd;
        s.regwrite = 1'b1;
        s.pc       = 32'h100;
        s.pcplus4  = 32'h104;
        return s;
    endfunction

    function automatic exp_e_t ee_mk(input logic pcsrc, input logic [31:0] target, input logic [4:0] rd,
                                     input logic regw);
        exp_e_t e;
        e.due = 0; e.pcsrc = pcsrc; e.target = target; e.rd = rd; e.regw = regw;
        return e;
    endfunction

    function automatic exp_m_t em_mk(input logic valid, input logic regw, input logic memw, input logic [1:0] rsrc,
                                     input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wdata,
                                     input logic [31:0] pcp4);
        exp_m_t m;
        m.due = 0; m.valid = valid; m.regw = regw; m.memw = memw; m.rsrc = rsrc;
        m.rd = rd; m.alu = alu; m.wdata = wdata; m.pcp4 = pcp4;
        return m;
    endfunction

    // Forwarding fields of a step serve the instruction already in EX during that cycle.
    task automatic step(input stim_t s, input exp_e_t ee, input exp_m_t em);
        @(posedge clk);
        #1;
        reset         = s.rst;
        flush_e       = s.flush;
        id_valid      = s.valid;
        id_pc         = s.pc;
        id_pcplus4    = s.pcplus4;
        id_rd1        = s.rd1;
        id_rd2        = s.rd2;
        id_imm        = s.imm;
        id_rs1        = 5'd1;
        id_rs2        = 5'd2;
        id_rd         = s.rd;
        id_alucontrol = s.aluc;
        id_alusrc     = s.alusrc;
        id_regwrite   = s.regwrite;
        id_memwrite   = s.memwrite;
        id_branch     = s.branch;
        id_jump       = s.jump;
        id_resultsrc  = s.resultsrc;
        forward_ae    = s.fa;
        forward_be    = s.fb;
        mem_aluresult = s.memres;
        wb_result     = s.wbres;
        ee.due = cyc + 1;
        em.due = cyc + 2;
        eq.push_back(ee);
        mq.push_back(em);
    endtask

    always @(negedge clk) begin
        exp_e_t e;
        exp_m_t m;
        while (eq.size() > 0 && eq[0].due <= cyc) begin
            e = eq.pop_front();
            nchk++;
            if (e.due != cyc || pcsrc_e !== e.pcsrc || pctarget_e !== e.target || e_rd !== e.rd
                || e_regwrite !== e.regw) begin
                nfail++;
                $display("FAIL ex_stage cyc=%0d: got pcsrc=%0b target=%h rd=%0d regw=%0b, want pcsrc=%0b target=%h rd=%0d regw=%0b (due %0d)",
                         cyc, pcsrc_e, pctarget_e, e_rd, e_regwrite, e.pcsrc, e.target, e.rd, e.regw, e.due);
            end
        end
        while (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            nchk++;
            if (m.due != cyc || m_valid !== m.valid || m_regwrite !== m.regw || m_memwrite !== m.memw
                || m_resultsrc !== m.rsrc || m_rd !== m.rd || m_aluresult !== m.alu
                || m_writedata !== m.wdata || m_pcplus4 !== m.pcp4) begin
                nfail++;
                $display("FAIL mem_stage cyc=%0d: got v=%0b rw=%0b mw=%0b rs=%0d rd=%0d alu=%h wd=%h pc4=%h, want v=%0b rw=%0b mw=%0b rs=%0d rd=%0d alu=%h wd=%h pc4=%h (due %0d)",
                         cyc, m_valid, m_regwrite, m_memwrite, m_resultsrc, m_rd, m_aluresult, m_writedata, m_pcplus4,
                         m.valid, m.regw, m.memw, m.rsrc, m.rd, m.alu, m.wdata, m.pcp4, m.due);
            end
        end
    end

    initial begin
        stim_t       s;
        exp_e_t      z_e;
        exp_m_t      z_m;
        logic [3:0]  ops [10];
        logic [31:0] res [10];

        ops = '{4'(ALU_ADD), 4'(ALU_SUB), 4'(ALU_MIN), 4'(ALU_MAX), 4'(ALU_SRL),
                4'(ALU_SLL), 4'(ALU_AND), 4'(ALU_OR), 4'(ALU_XOR), 4'b1111};
        res = '{32'hFFFFFFFE, 32'hFFFFFFF8, 32'hFFFFFFFB, 32'h00000003, 32'h1FFFFFFF,
                32'hFFFFFFD8, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF8, 32'h00000000};
        z_e = ee_mk(1'b0, 32'h0, 5'd0, 1'b0);
        z_m = em_mk(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);

        reset = 1'b1; flush_e = 1'b0; id_valid = 1'b0;
        id_pc = '0; id_pcplus4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alucontrol = '0;
        id_alusrc = 1'b0; id_regwrite = 1'b0; id_memwrite = 1'b0; id_branch = 1'b0; id_jump = 1'b0;
        id_resultsrc = '0; forward_ae = '0; forward_be = '0; mem_aluresult = '0; wb_result = '0;

        // reset held with a live jump on the inputs
        s = alu_i(4'(ALU_ADD), 32'd5, 32'd6, 5'd3); s.rst = 1'b1; s.jump = 1'b1; s.pc = 32'h80;
        step(s, z_e, z_m);
        step(s, z_e, z_m);

        // ALU sweep with rd1 = -5, rd2 = 3
        for (int i = 0; i < 10; i++) begin
            s = alu_i(ops[i], 32'hFFFFFFFB, 32'd3, 5'(i + 1));
            step(s, ee_mk(1'b0, 32'h100, 5'(i + 1), 1'b1),
                 em_mk(1'b1, 1'b1, 1'b0, 2'd0, 5'(i + 1), res[i], 32'd3, 32'h104));
        end

        // forwarding: A from MEM, B from WB, immediate selected
        s = alu_i(4'(ALU_ADD), 32'hDEAD, 32'h55, 5'd11); s.alusrc = 1'b1; s.imm = 32'd4;
        s.pc = 32'h200; s.pcplus4 = 32'h204;
        step(s, ee_mk(1'b0, 32'h204, 5'd11, 1'b1), em_mk(1'b1, 1'b1, 1'b0, 2'd0, 5'd11, 32'h104, 32'h20, 32'h204));
        s = alu_i(4'(ALU_ADD), 32'd5, 32'd6, 5'd12);
        s.fa = 2'b10; s.memres = 32'h100; s.fb = 2'b01; s.wbres = 32'h20;
        step(s, ee_mk(1'b0, 32'h100, 5'd12, 1'b1), em_mk(1'b1, 1'b1, 1'b0, 2'd0, 5'd12, 32'hB, 32'd6, 32'h104));

        // taken branch; select 11 on the previous instruction must still pick the register
        s = alu_i(4'(ALU_SUB), 32'd7, 32'd7, 5'd0); s.regwrite = 1'b0; s.branch = 1'b1;
        s.pc = 32'h40; s.pcplus4 = 32'h44; s.imm = 32'h10;
        s.fa = 2'b11; s.fb = 2'b11; s.memres = 32'hBAD; s.wbres = 32'hBAD;
        step(s, ee_mk(1'b1, 32'h50, 5'd0, 1'b0), em_mk(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'd7, 32'h44));
        s.rd2 = 32'd8; s.fa = 2'b00; s.fb = 2'b00;
        step(s, ee_mk(1'b0, 32'h50, 5'd0, 1'b0), em_mk(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 32'hFFFFFFFF, 32'd8, 32'h44));

        // taken branch in EX while the next instruction is flushed
        s.rd2 = 32'd7;
        step(s, ee_mk(1'b1, 32'h50, 5'd0, 1'b0), em_mk(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'd7, 32'h44));
        s = alu_i(4'(ALU_ADD), 32'd1, 32'd2, 5'd13); s.flush = 1'b1; s.memwrite = 1'b1; s.jump = 1'b1;
        step(s, z_e, z_m);

        // jump with target wrap
        s = alu_i(4'(ALU_ADD), 32'd0, 32'd0, 5'd14); s.jump = 1'b1; s.pc = 32'hFFFFFFF0;
        s.pcplus4 = 32'hFFFFFFF4; s.imm = 32'h20; s.resultsrc = 2'b10;
        step(s, ee_mk(1'b1, 32'h10, 5'd14, 1'b1), em_mk(1'b1, 1'b1, 1'b0, 2'd2, 5'd14, 32'h0, 32'h0, 32'hFFFFFFF4));

        // id_valid low becomes a bubble
        s = alu_i(4'(ALU_ADD), 32'd9, 32'd9, 5'd15); s.valid = 1'b0; s.memwrite = 1'b1; s.jump = 1'b1;
        step(s, z_e, z_m);

        // store: address from immediate, data from rs2
        s = alu_i(4'(ALU_ADD), 32'h1000, 32'hCAFEF00D, 5'd0); s.regwrite = 1'b0; s.memwrite = 1'b1;
        s.alusrc = 1'b1; s.imm = 32'd8;
        step(s, ee_mk(1'b0, 32'h108, 5'd0, 1'b0), em_mk(1'b1, 1'b0, 1'b1, 2'd0, 5'd0, 32'h1008, 32'hCAFEF00D, 32'h104));

        // reset mid-stream discards both in-flight instructions
        s = alu_i(4'(ALU_XOR), 32'hF0, 32'h0F, 5'd16);
        step(s, ee_mk(1'b0, 32'h100, 5'd16, 1'b1), z_m);
        s = alu_i(4'(ALU_OR), 32'd1, 32'd2, 5'd17); s.rst = 1'b1; s.jump = 1'b1;
        step(s, z_e, z_m);
        s = alu_i(4'(ALU_AND), 32'hFF, 32'h0F, 5'd18);
        step(s, ee_mk(1'b0, 32'h100, 5'd18, 1'b1), em_mk(1'b1, 1'b1, 1'b0, 2'd0, 5'd18, 32'hF, 32'hF, 32'h104));

        s = alu_i(4'(ALU_ADD), 32'd0, 32'd0, 5'd0); s.valid = 1'b0;
        step(s, z_e, z_m);
        step(s, z_e, z_m);

        for (int i = 0; i < 10 && (eq.size() > 0 || mq.size() > 0); i++) @(negedge clk);
        #1;
        if (eq.size() > 0 || mq.size() > 0) begin
            nchk++;
            nfail++;
            $display("FAIL drain: %0d ex and %0d mem expectations left, want 0", eq.size(), mq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
